// File: rtl/pe_sched_pkg.sv
// Shared definitions for the pe_array tile scheduler: state encoding, tile
// limits and the small combinational helpers used by the top and the iterator.
package pe_sched_pkg;

    localparam int TILE_H_DEF     = 32;
    localparam int TILE_OC_DEF    = 64;
    localparam int LAYER_H_W_DEF  = 8;
    localparam int LAYER_OC_W_DEF = 10;
    localparam int TIMEOUT_W_DEF  = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_NEXT  = 3'd6,
        ST_ERR   = 3'd7
    } sched_state_e;

    function automatic logic cfg_legal(input logic [2:0] k, input logic [2:0] stride,
                                       input logic h_nz, input logic oc_nz);
        return (k != 3'd0) && (k <= 3'd3) && (stride != 3'd0) && h_nz && oc_nz;
    endfunction

    function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/pe_tile_iter.sv
// Tile base iterator: walks output rows (inner) then output channels (outer)
// and reports the size of the current tile and whether it is the last one.
module pe_tile_iter
    import pe_sched_pkg::*;
#(
    parameter int TILE_H     = TILE_H_DEF,
    parameter int TILE_OC    = TILE_OC_DEF,
    parameter int LAYER_H_W  = LAYER_H_W_DEF,
    parameter int LAYER_OC_W = LAYER_OC_W_DEF
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_advance,
    input  logic [LAYER_H_W-1:0]  i_layer_h,
    input  logic [LAYER_OC_W-1:0] i_layer_oc,
    output logic [LAYER_H_W-1:0]  o_row_base,
    output logic [LAYER_OC_W-1:0] o_oc_base,
    output logic [5:0]            o_tile_h,
    output logic [7:0]            o_tile_oc,
    output logic                  o_last_tile
);

    logic [LAYER_H_W-1:0]  r_row_base;
    logic [LAYER_OC_W-1:0] r_oc_base;
    logic [15:0]           w_tile_h16;
    logic [15:0]           w_tile_oc16;
    logic [15:0]           w_row_end;
    logic [15:0]           w_oc_end;
    logic                  w_row_wrap;

    // Tile geometry; 16-bit math keeps the end-of-tile sums free of overflow.
    always_comb begin
        w_tile_h16  = min_u16(16'(TILE_H), 16'(i_layer_h) - 16'(r_row_base));
        w_tile_oc16 = min_u16(16'(TILE_OC), 16'(i_layer_oc) - 16'(r_oc_base));
        w_row_end   = 16'(r_row_base) + w_tile_h16;
        w_oc_end    = 16'(r_oc_base) + w_tile_oc16;
        w_row_wrap  = (w_row_end >= 16'(i_layer_h));
        o_last_tile = w_row_wrap && (w_oc_end >= 16'(i_layer_oc));
    end

    // Base registers: rows advance first, then wrap and step the OC base.
    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            r_row_base <= '0;
            r_oc_base  <= '0;
        end else if (i_advance) begin
            if (w_row_wrap) begin
                r_row_base <= '0;
                r_oc_base  <= r_oc_base + LAYER_OC_W'(TILE_OC);
            end else begin
                r_row_base <= w_row_end[LAYER_H_W-1:0];
            end
        end
    end

    assign o_row_base = r_row_base;
    assign o_oc_base  = r_oc_base;
    assign o_tile_h   = w_tile_h16[5:0];
    assign o_tile_oc  = w_tile_oc16[7:0];

endmodule

// File: rtl/pe_tile_scheduler.sv
// Layer-level sequencer for pe_array: splits a layer into output tiles and runs
// the row-mem load, pe_array compute and psum drain handshakes for each tile.
module pe_tile_scheduler
    import pe_sched_pkg::*;
#(
    parameter int TILE_H     = TILE_H_DEF,
    parameter int TILE_OC    = TILE_OC_DEF,
    parameter int LAYER_H_W  = LAYER_H_W_DEF,
    parameter int LAYER_OC_W = LAYER_OC_W_DEF,
    parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [2:0]            cfg_k,
    input  logic [2:0]            cfg_stride,
    input  logic [5:0]            cfg_img_w,
    input  logic [LAYER_H_W-1:0]  cfg_layer_h,
    input  logic [LAYER_OC_W-1:0] cfg_layer_oc,
    input  logic                  abort,
    output logic                  busy,
    output logic                  layer_done,
    output logic                  error,
    output logic                  load_req,
    output logic [LAYER_OC_W-1:0] load_oc_base,
    output logic [LAYER_H_W-1:0]  load_row_base,
    output logic [5:0]            load_tile_h,
    output logic [7:0]            load_tile_oc,
    input  logic                  load_ack,
    output logic                  pe_start,
    output logic [2:0]            pe_k,
    output logic [2:0]            pe_stride,
    output logic [5:0]            pe_img_h,
    output logic [5:0]            pe_img_w,
    output logic [7:0]            pe_oc,
    input  logic                  pe_done,
    output logic                  drain_req,
    input  logic                  drain_ack
);

    // Watchdog fires on the cycle the counter would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    sched_state_e          r_state;
    sched_state_e          w_next;
    logic [2:0]            r_k;
    logic [2:0]            r_stride;
    logic [5:0]            r_img_w;
    logic [LAYER_H_W-1:0]  r_layer_h;
    logic [LAYER_OC_W-1:0] r_layer_oc;
    logic [TIMEOUT_W-1:0]  r_wd_cnt;
    logic                  r_error;
    logic                  r_layer_done;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_in_compute;
    logic                  w_wd_hit;
    logic                  w_last;
    logic                  w_advance;
    logic [5:0]            w_tile_h;
    logic [7:0]            w_tile_oc;

    assign w_legal      = cfg_legal(cfg_k, cfg_stride, |cfg_layer_h, |cfg_layer_oc);
    assign w_accept     = ~abort & cfg_start & ((r_state == ST_IDLE) | (r_state == ST_ERR));
    assign w_in_compute = (r_state == ST_ARM) | (r_state == ST_RUN);
    assign w_wd_hit     = w_in_compute & (r_wd_cnt == WD_LAST);
    assign w_advance    = ~abort & (r_state == ST_NEXT);

    pe_tile_iter #(
        .TILE_H     (TILE_H),
        .TILE_OC    (TILE_OC),
        .LAYER_H_W  (LAYER_H_W),
        .LAYER_OC_W (LAYER_OC_W)
    ) u_iter (
        .clk         (clk),
        .i_reset     (reset),
        .i_clear     (w_accept),
        .i_advance   (w_advance),
        .i_layer_h   (r_layer_h),
        .i_layer_oc  (r_layer_oc),
        .o_row_base  (load_row_base),
        .o_oc_base   (load_oc_base),
        .o_tile_h    (w_tile_h),
        .o_tile_oc   (w_tile_oc),
        .o_last_tile (w_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort beats the watchdog, which beats the handshakes.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else if (w_wd_hit) begin
            w_next = ST_ERR;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR: w_next = cfg_start ? (w_legal ? ST_LOAD : ST_ERR) : r_state;
                ST_LOAD:         w_next = load_ack ? ST_START : ST_LOAD;
                ST_START:        w_next = ST_ARM;
                ST_ARM:          w_next = pe_done ? ST_ARM : ST_RUN;
                ST_RUN:          w_next = pe_done ? ST_DRAIN : ST_RUN;
                ST_DRAIN:        w_next = drain_ack ? ST_NEXT : ST_DRAIN;
                ST_NEXT:         w_next = w_last ? ST_IDLE : ST_LOAD;
                default:         w_next = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        load_req  = 1'b0;
        pe_start  = 1'b0;
        drain_req = 1'b0;
        busy      = (r_state != ST_IDLE) && (r_state != ST_ERR);
        case (r_state)
            ST_LOAD:  load_req  = 1'b1;
            ST_START: pe_start  = 1'b1;
            ST_DRAIN: drain_req = 1'b1;
            default:  load_req  = 1'b0;
        endcase
    end

    // Layer configuration, captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k        <= 3'd0;
            r_stride   <= 3'd0;
            r_img_w    <= 6'd0;
            r_layer_h  <= '0;
            r_layer_oc <= '0;
        end else if (w_accept) begin
            r_k        <= cfg_k;
            r_stride   <= cfg_stride;
            r_img_w    <= cfg_img_w;
            r_layer_h  <= cfg_layer_h;
            r_layer_oc <= cfg_layer_oc;
        end
    end

    // Compute watchdog: cleared in START, counting while waiting on pe_array.
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_START)) begin
            r_wd_cnt <= '0;
        end else if (w_in_compute) begin
            r_wd_cnt <= r_wd_cnt + TIMEOUT_W'(1);
        end
    end

    // Sticky error and the end-of-layer pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error      <= 1'b0;
            r_layer_done <= 1'b0;
        end else begin
            r_layer_done <= ~abort & (r_state == ST_NEXT) & w_last;
            if (abort) begin
                r_error <= r_error;
            end else if (w_wd_hit) begin
                r_error <= 1'b1;
            end else if (w_accept) begin
                r_error <= ~w_legal;
            end
        end
    end

    assign error        = r_error;
    assign layer_done   = r_layer_done;
    assign load_tile_h  = w_tile_h;
    assign load_tile_oc = w_tile_oc;
    assign pe_k         = r_k;
    assign pe_stride    = r_stride;
    assign pe_img_h     = w_tile_h;
    assign pe_img_w     = r_img_w;
    assign pe_oc        = w_tile_oc;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Self-checking bench for pe_tile_scheduler: randomized layers against a
// tile-list reference model, plus illegal-config, watchdog, abort and reset.
module tb_pe_tile_scheduler;

    localparam int M_TILE_H  = 32;
    localparam int M_TILE_OC = 64;

    typedef struct {
        int oc_base;
        int row_base;
        int th;
        int toc;
    } tile_t;

    logic       clk = 1'b0;
    logic       reset, cfg_start, abort, load_ack, pe_done, drain_ack;
    logic [2:0] cfg_k, cfg_stride;
    logic [5:0] cfg_img_w;
    logic [7:0] cfg_layer_h;
    logic [9:0] cfg_layer_oc;

    logic       busy, layer_done, error, load_req, pe_start, drain_req;
    logic [9:0] load_oc_base;
    logic [7:0] load_row_base, load_tile_oc, pe_oc;
    logic [5:0] load_tile_h, pe_img_h, pe_img_w;
    logic [2:0] pe_k, pe_stride;

    logic       wd_busy, wd_layer_done, wd_error, wd_load_req, wd_pe_start, wd_drain_req;
    logic [9:0] wd_load_oc_base;
    logic [7:0] wd_load_row_base, wd_load_tile_oc, wd_pe_oc;
    logic [5:0] wd_load_tile_h, wd_pe_img_h, wd_pe_img_w;
    logic [2:0] wd_pe_k, wd_pe_stride;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pe_tile_scheduler dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_k(cfg_k), .cfg_stride(cfg_stride),
        .cfg_img_w(cfg_img_w), .cfg_layer_h(cfg_layer_h), .cfg_layer_oc(cfg_layer_oc), .abort(abort),
        .busy(busy), .layer_done(layer_done), .error(error), .load_req(load_req),
        .load_oc_base(load_oc_base), .load_row_base(load_row_base), .load_tile_h(load_tile_h),
        .load_tile_oc(load_tile_oc), .load_ack(load_ack), .pe_start(pe_start), .pe_k(pe_k),
        .pe_stride(pe_stride), .pe_img_h(pe_img_h), .pe_img_w(pe_img_w), .pe_oc(pe_oc),
        .pe_done(pe_done), .drain_req(drain_req), .drain_ack(drain_ack)
    );

    pe_tile_scheduler #(.TIMEOUT_W(4)) dut_wd (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_k(cfg_k), .cfg_stride(cfg_stride),
        .cfg_img_w(cfg_img_w), .cfg_layer_h(cfg_layer_h), .cfg_layer_oc(cfg_layer_oc), .abort(abort),
        .busy(wd_busy), .layer_done(wd_layer_done), .error(wd_error), .load_req(wd_load_req),
        .load_oc_base(wd_load_oc_base), .load_row_base(wd_load_row_base), .load_tile_h(wd_load_tile_h),
        .load_tile_oc(wd_load_tile_oc), .load_ack(load_ack), .pe_start(wd_pe_start), .pe_k(wd_pe_k),
        .pe_stride(wd_pe_stride), .pe_img_h(wd_pe_img_h), .pe_img_w(wd_pe_img_w), .pe_oc(wd_pe_oc),
        .pe_done(pe_done), .drain_req(wd_drain_req), .drain_ack(drain_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic spurious();
        load_ack  = 1'($urandom_range(0, 1));
        drain_ack = 1'($urandom_range(0, 1));
        cfg_start = 1'($urandom_range(0, 1));
    endtask

    task automatic quiet();
        load_ack  = 1'b0;
        drain_ack = 1'b0;
        cfg_start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, layer_done, 0);
        check({tag, "_err"}, error, 0);
        check({tag, "_lreq"}, load_req, 0);
        check({tag, "_locb"}, load_oc_base, 0);
        check({tag, "_lrowb"}, load_row_base, 0);
        check({tag, "_lth"}, load_tile_h, 0);
        check({tag, "_ltoc"}, load_tile_oc, 0);
        check({tag, "_pst"}, pe_start, 0);
        check({tag, "_pk"}, pe_k, 0);
        check({tag, "_ps"}, pe_stride, 0);
        check({tag, "_pih"}, pe_img_h, 0);
        check({tag, "_piw"}, pe_img_w, 0);
        check({tag, "_poc"}, pe_oc, 0);
        check({tag, "_dreq"}, drain_req, 0);
    endtask

    // Runs one layer; abort_tile/rst_tile >= 0 interrupt that tile in RUN/DRAIN.
    task automatic run_layer(input int h, input int oc, input int a_hi, input int b_lo,
                             input int abort_tile, input int rst_tile);
        tile_t tiles[$];
        int    k_v, s_v, w_v, n;
        k_v = $urandom_range(1, 3);
        s_v = $urandom_range(1, 7);
        w_v = $urandom_range(0, 63);
        tiles = {};
        for (int o = 0; o < oc; o += M_TILE_OC)
            for (int r = 0; r < h; r += M_TILE_H)
                tiles.push_back('{o, r, (h - r < M_TILE_H) ? h - r : M_TILE_H,
                                  (oc - o < M_TILE_OC) ? oc - o : M_TILE_OC});
        cfg_k = 3'(k_v); cfg_stride = 3'(s_v); cfg_img_w = 6'(w_v);
        cfg_layer_h = 8'(h); cfg_layer_oc = 10'(oc); cfg_start = 1'b1;
        tick();
        cfg_start    = 1'b0;
        cfg_k        = 3'($urandom); cfg_stride = 3'($urandom); cfg_img_w = 6'($urandom);
        cfg_layer_h  = 8'($urandom); cfg_layer_oc = 10'($urandom);
        check("err_clr", error, 0);
        for (int i = 0; i < tiles.size(); i++) begin
            check("load_req", load_req, 1);
            check("busy", busy, 1);
            check("ld_oc_base", load_oc_base, tiles[i].oc_base);
            check("ld_row_base", load_row_base, tiles[i].row_base);
            check("ld_tile_h", load_tile_h, tiles[i].th);
            check("ld_tile_oc", load_tile_oc, tiles[i].toc);
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                drain_ack = 1'($urandom_range(0, 1));
                tick();
            end
            drain_ack = 1'b0;
            check("load_hold", load_req, 1);
            check("ld_row_hold", load_row_base, tiles[i].row_base);
            load_ack = 1'b1;
            tick();
            load_ack = 1'b0;
            check("pe_start", pe_start, 1);
            check("load_drop", load_req, 0);
            check("pe_k", pe_k, k_v);
            check("pe_stride", pe_stride, s_v);
            check("pe_img_w", pe_img_w, w_v);
            check("pe_img_h", pe_img_h, tiles[i].th);
            check("pe_oc", pe_oc, tiles[i].toc);
            pe_done = 1'b1;
            spurious();
            tick();
            check("pe_start_pulse", pe_start, 0);
            for (int j = 0; j < a_hi; j++) begin
                spurious();
                tick();
                check("no_drain_arm", drain_req, 0);
            end
            pe_done = 1'b0;
            for (int j = 0; j < b_lo; j++) begin
                spurious();
                tick();
                check("no_drain_run", drain_req, 0);
                check("busy_run", busy, 1);
            end
            quiet();
            check("pe_oc_stable", pe_oc, tiles[i].toc);
            check("pe_k_stable", pe_k, k_v);
            if (i == abort_tile) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                pe_done = 1'b1;
                check("abort_busy", busy, 0);
                check("abort_lreq", load_req, 0);
                check("abort_pst", pe_start, 0);
                check("abort_dreq", drain_req, 0);
                check("abort_done", layer_done, 0);
                check("abort_err", error, 0);
                return;
            end
            spurious();
            pe_done = 1'b1;
            tick();
            quiet();
            check("drain_req", drain_req, 1);
            if (i == rst_tile) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_zero("rst_drain");
                return;
            end
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                load_ack = 1'($urandom_range(0, 1));
                tick();
            end
            load_ack = 1'b0;
            check("drain_hold", drain_req, 1);
            drain_ack = 1'b1;
            tick();
            drain_ack = 1'b0;
            check("drain_drop", drain_req, 0);
            check("done_early", layer_done, 0);
            tick();
            if (i == tiles.size() - 1) begin
                check("layer_done", layer_done, 1);
                check("busy_after", busy, 0);
                check("no_reload", load_req, 0);
                tick();
                check("done_pulse", layer_done, 0);
            end else begin
                check("no_done_mid", layer_done, 0);
            end
        end
    endtask

    task automatic bad_cfg(input int k, input int s, input int h, input int oc);
        cfg_k = 3'(k); cfg_stride = 3'(s); cfg_layer_h = 8'(h); cfg_layer_oc = 10'(oc);
        cfg_img_w = 6'd5; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("bad_err", error, 1);
        check("bad_busy", busy, 0);
        check("bad_lreq", load_req, 0);
        repeat (3) begin
            tick();
            check("bad_err_hold", error, 1);
            check("bad_lreq_hold", load_req, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cfg_start = 1'b0; abort = 1'b0; load_ack = 1'b0; drain_ack = 1'b0;
        pe_done = 1'b1; cfg_k = 3'd0; cfg_stride = 3'd0; cfg_img_w = 6'd0;
        cfg_layer_h = 8'd0; cfg_layer_oc = 10'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_zero("reset");

        run_layer(32, 64, 0, 1, -1, -1);
        run_layer(70, 100, 4, 10, -1, -1);

        bad_cfg(0, 1, 10, 10);
        bad_cfg(4, 1, 10, 10);
        bad_cfg(1, 0, 10, 10);
        bad_cfg(2, 3, 0, 10);
        bad_cfg(2, 3, 10, 0);

        for (int r = 0; r < 5; r++)
            run_layer($urandom_range(1, 255), $urandom_range(1, 300),
                      $urandom_range(0, 4), $urandom_range(1, 5), -1, -1);

        run_layer(70, 100, 1, 2, 1, -1);
        run_layer(20, 30, 2, 3, -1, -1);
        run_layer(255, 1023, 0, 1, -1, -1);
        run_layer(70, 100, 0, 2, -1, 3);

        // Watchdog on the narrow-counter instance: pe_done held low after pe_start.
        cfg_k = 3'd3; cfg_stride = 3'd1; cfg_img_w = 6'd8;
        cfg_layer_h = 8'd10; cfg_layer_oc = 10'd10; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("wd_lreq", wd_load_req, 1);
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        check("wd_pe_start", wd_pe_start, 1);
        pe_done = 1'b0;
        repeat (15) tick();
        check("wd_busy_pre", wd_busy, 1);
        check("wd_err_pre", wd_error, 0);
        tick();
        check("wd_err", wd_error, 1);
        check("wd_busy", wd_busy, 0);
        check("wd_no_drain", wd_drain_req, 0);
        check("wd_no_pst", wd_pe_start, 0);
        check("wide_wd_busy", busy, 1);
        pe_done = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wd_rst_err", wd_error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_tile_scheduler.md
Name: pe_tile_scheduler

Overview:
Layer-level sequencer for pe_array. It splits a convolution layer into output tiles of up to TILE_H output rows by TILE_OC output channels. For each tile it runs three handshakes in order: row-mem load, pe_array compute, psum drain.
It sits between the host config registers and pe_array, the row-mem loader and the psum quantize/writeback unit.

Parameters:
TILE_H, 32, max output rows per tile (pe_array IMG_H limit)
TILE_OC, 64, max output channels per tile (pe_array OC limit)
LAYER_H_W, 8, width of layer height field
LAYER_OC_W, 10, width of layer OC field
TIMEOUT_W, 20, width of per-tile compute watchdog counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_start  in  1  layer start pulse; sampled only in IDLE
cfg_k  in  3  kernel size, legal 1..3
cfg_stride  in  3  stride, legal 1..7
cfg_img_w  in  6  tile width, passed through to pe_array
cfg_layer_h  in  LAYER_H_W  layer output height
cfg_layer_oc  in  LAYER_OC_W  layer output channels
abort  in  1  synchronous abort
busy  out  1  high in every state except IDLE and ERR
layer_done  out  1  one-cycle pulse after the last tile drains
error  out  1  sticky; cleared by the next accepted cfg_start or by reset
load_req  out  1  tile load request, level
load_oc_base  out  LAYER_OC_W  first OC of the tile
load_row_base  out  LAYER_H_W  first output row of the tile
load_tile_h  out  6  rows in the tile
load_tile_oc  out  8  OCs in the tile
load_ack  in  1  one-cycle load complete
pe_start  out  1  one-cycle start pulse to pe_array
pe_k, pe_stride  out  3 each  held config
pe_img_h  out  6  equals load_tile_h
pe_img_w  out  6  latched cfg_img_w
pe_oc  out  8  equals load_tile_oc
pe_done  in  1  pe_array done (level, high when pe_array is idle)
drain_req  out  1  psum drain request, level
drain_ack  in  1  one-cycle drain complete

Behaviour:
- Reset: state IDLE; every output 0; counters 0; error 0.
- Config capture: cfg_* are latched on the accepted cfg_start. Later changes to cfg_* have no effect until the next layer.
- Illegal config: k=0, k>3, stride=0, layer_h=0 or layer_oc=0.
  - Goes to ERR on the cycle after cfg_start; error=1.
  - No request is ever raised.
- Tile order: OC outer, rows inner.
  - tile_h = min(TILE_H, layer_h - row_base); tile_oc = min(TILE_OC, layer_oc - oc_base).
  - Tile count is ceil(H/TILE_H) * ceil(OC/TILE_OC).
- States:
  - IDLE: on a legal cfg_start go to LOAD and clear the tile bases. cfg_start in any other state is ignored.
  - LOAD: load_req=1 with stable tile fields. On load_ack go to START. load_req drops on the cycle after the ack.
  - START: pe_start=1 for exactly one cycle, then go to ARM.
  - ARM: wait for pe_done=0, then go to RUN. This prevents pe_array's idle-high done from being read as completion.
  - RUN: wait for pe_done=1, then go to DRAIN.
  - DRAIN: drain_req=1. On drain_ack go to NEXT.
  - NEXT (one cycle): if row_base + tile_h < layer_h, advance row_base. Otherwise row_base=0 and oc_base += TILE_OC. If no tiles remain, pulse layer_done and go to IDLE. Otherwise go to LOAD.
  - ERR: hold until a cfg_start (legal or not), which re-evaluates the config exactly as IDLE does.
- Latency:
  - cfg_start at cycle t gives load_req at t+1.
  - load_ack at t gives pe_start at t+1.
  - pe_done rising in RUN at t gives drain_req at t+1.
  - drain_ack on the last tile at t gives layer_done at t+2.
- Watchdog: the counter clears on entry to START and counts in ARM and RUN. At all-ones: go to ERR, error=1, pe_start=0.
- Stable outputs: pe_k, pe_stride, pe_img_h, pe_img_w and pe_oc stay constant from START until leaving RUN.
- Early acks: a load_ack outside LOAD or a drain_ack outside DRAIN is ignored.
- Abort or reset mid-operation: go to IDLE next cycle; all requests and pulses drop to 0 that cycle; error unchanged by abort.
- Precedence: reset > abort > watchdog > normal transitions.

Decomposition:
- Shared package pe_sched_pkg: state encodings, TILE_H and TILE_OC defaults, the config-legality function, the min-helper for the tile-size calculation.
- One sub-module, pe_tile_iter: holds row_base and oc_base. Provides clear, advance, tile_h/tile_oc calculation and the last-tile flag.

Test Plan:
- H=32, OC=64, K=3, S=1 -> exactly one load_req (0,0,32,64), one pe_start, one drain_req; layer_done 2 cycles after drain_ack; busy low afterwards.
- H=70, OC=100 -> six tiles in order:
  - (oc,row,h,oc#) = (0,0,32,64), (0,32,32,64), (0,64,6,64), (64,0,32,36), (64,32,32,36), (64,64,6,36)
  - then one layer_done.
- K=0, then K=4, then S=0 -> error=1 on the cycle after cfg_start; load_req never asserted. A later legal cfg_start clears error and runs normally.
- TIMEOUT_W=4 with pe_done held 0 after pe_start -> ERR after 15 cycles in ARM/RUN, error=1, no drain_req.
- pe_done held 1 for 5 cycles after pe_start, then 0 for 10, then 1 -> drain_req only after the second rising edge. A second cfg_start while busy is ignored.
- abort asserted in RUN (tile 2 of 6) -> IDLE next cycle, all requests 0. Reset asserted in DRAIN -> all outputs 0 next cycle.
